// File: rtl/pudding_dac_seq.sv
`default_nettype none
// ============================================================================
//  Module   : pudding_dac_seq
//  Purpose  : Front-end controller for an N-cell unary current-steering DAC.
//             A shift/load chain feeds a state register that drives the
//             ON/ONB pairs of the DAC macro. The load path supports direct
//             copy, thermometer-code expansion, and an autonomous triangular
//             ramp sequencer for linearity sweeps.
//  Ports    : clk, rst_n          clock, asynchronous active-low reset
//             data_in[LANES]      serial lanes, data_in[0] enters chain bit 0
//             shift               shift chain by LANES
//             transfer, dir       chain<->state transfer strobe and direction
//             mode[2]             0 DIRECT, 1 THERMO, 2 RAMP, 3 HOLD
//             en_in               asynchronous DAC enable pin
//             chain_tap/state_tap top TAPW bits of chain / state
//             cell_on/cell_on_b   DAC cell enables and their complement
//             dac_en              synchronised enable
//             busy                ramp sequencer running
//  Revision : 1.0  initial release
// ============================================================================
module pudding_dac_seq #(
  parameter int N     = 128,
  parameter int LANES = 1,
  parameter int DIVW  = 16,
  parameter int TAPW  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [LANES-1:0] data_in,
  input  logic             shift,
  input  logic             transfer,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic             en_in,
  output logic [TAPW-1:0]  chain_tap,
  output logic [TAPW-1:0]  state_tap,
  output logic [N-1:0]     cell_on,
  output logic [N-1:0]     cell_on_b,
  output logic             dac_en,
  output logic             busy
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] C_LVL_MAX = CW'(N);
  localparam logic [CW-1:0] C_LVL_TOP = CW'(N - 1);

  typedef enum logic [1:0] {
    MODE_DIRECT = 2'd0,
    MODE_THERMO = 2'd1,
    MODE_RAMP   = 2'd2,
    MODE_HOLD   = 2'd3
  } mode_e;

  logic [N-1:0]    r_chain;
  logic [N-1:0]    r_state;
  logic [N-1:0]    r_state_b;
  logic [CW-1:0]   r_level;
  logic            r_up;
  logic [DIVW-1:0] r_cnt;
  logic [DIVW-1:0] r_div;
  logic            r_run;
  logic            r_en_meta;
  logic            r_en_sync;

  logic [CW-1:0]   w_code;
  logic [CW-1:0]   w_clamp;
  logic [CW-1:0]   w_next_level;
  logic            w_next_up;
  logic [N-1:0]    w_readback;

  // Thermometer expansion: cell k is on when k < lvl.
  function automatic logic [N-1:0] therm(input logic [CW-1:0] lvl);
    logic [N-1:0] t;
    for (int k = 0; k < N; k++) begin
      t[k] = (k < int'(lvl));
    end
    return t;
  endfunction

  assign w_code     = r_chain[CW-1:0];
  assign w_clamp    = (w_code > C_LVL_MAX) ? C_LVL_MAX : w_code;
  assign w_readback = {{(N-CW){1'b0}}, r_level};

  // Triangle step: reverse at the ends without overshooting, so the
  // waveform visits 0 and N exactly once per period of 2N steps.
  always_comb begin
    w_next_level = r_level;
    w_next_up    = r_up;
    if (r_up) begin
      if (r_level == C_LVL_MAX) begin
        w_next_up    = 1'b0;
        w_next_level = C_LVL_TOP;
      end else begin
        w_next_level = r_level + CW'(1);
      end
    end else begin
      if (r_level == '0) begin
        w_next_up    = 1'b1;
        w_next_level = CW'(1);
      end else begin
        w_next_level = r_level - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chain   <= '0;
      r_state   <= '0;
      r_state_b <= '1;
      r_level   <= '0;
      r_up      <= 1'b1;
      r_cnt     <= '0;
      r_div     <= '0;
      r_run     <= 1'b0;
      r_en_meta <= 1'b0;
      r_en_sync <= 1'b0;
    end else begin
      r_en_meta <= en_in;
      r_en_sync <= r_en_meta;

      // Ramp engine; a transfer below may override these assignments.
      if (mode != MODE_RAMP) begin
        r_run <= 1'b0;
        r_cnt <= '0;
      end else if (r_run) begin
        if (r_cnt == r_div) begin
          r_cnt     <= '0;
          r_level   <= w_next_level;
          r_up      <= w_next_up;
          r_state   <= therm(w_next_level);
          r_state_b <= ~therm(w_next_level);
        end else begin
          r_cnt <= r_cnt + DIVW'(1);
        end
      end

      // Transfer takes priority over shift in the same cycle.
      if (transfer) begin
        case (mode)
          MODE_DIRECT: begin
            if (dir) begin
              r_state   <= r_chain;
              r_state_b <= ~r_chain;
            end else begin
              r_chain <= r_state;
            end
          end
          MODE_THERMO: begin
            if (dir) begin
              r_level   <= w_clamp;
              r_state   <= therm(w_clamp);
              r_state_b <= ~therm(w_clamp);
            end else begin
              r_chain <= w_readback;
            end
          end
          MODE_RAMP: begin
            if (dir) begin
              r_div     <= r_chain[DIVW-1:0];
              r_level   <= '0;
              r_up      <= 1'b1;
              r_cnt     <= '0;
              r_run     <= 1'b1;
              r_state   <= '0;
              r_state_b <= '1;
            end else begin
              r_chain <= w_readback;
            end
          end
          default: begin
          end
        endcase
      end else if (shift) begin
        r_chain <= {r_chain[N-LANES-1:0], data_in};
      end
    end
  end

  assign chain_tap = r_chain[N-1 -: TAPW];
  assign state_tap = r_state[N-1 -: TAPW];
  assign cell_on   = r_state;
  assign cell_on_b = r_state_b;
  assign dac_en    = r_en_sync;
  assign busy      = r_run && (mode == MODE_RAMP);

endmodule
`default_nettype wire

// File: tb/tb_pudding_dac_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pudding_dac_seq
//  Purpose  : Scoreboard bench for pudding_dac_seq. A driver issues directed
//             and random stimulus and pushes the reference model's expected
//             outputs into a queue; a monitor pops and compares them.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pudding_dac_seq;

  localparam int N     = 128;
  localparam int LANES = 1;
  localparam int DIVW  = 16;
  localparam int TAPW  = 8;
  localparam int CW    = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [LANES-1:0] data_in;
  logic             shift;
  logic             transfer;
  logic             dir;
  logic [1:0]       mode;
  logic             en_in;
  logic [TAPW-1:0]  chain_tap;
  logic [TAPW-1:0]  state_tap;
  logic [N-1:0]     cell_on;
  logic [N-1:0]     cell_on_b;
  logic             dac_en;
  logic             busy;

  pudding_dac_seq #(.N(N), .LANES(LANES), .DIVW(DIVW), .TAPW(TAPW)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .shift(shift),
    .transfer(transfer), .dir(dir), .mode(mode), .en_in(en_in),
    .chain_tap(chain_tap), .state_tap(state_tap), .cell_on(cell_on),
    .cell_on_b(cell_on_b), .dac_en(dac_en), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [N-1:0] state;
    logic [N-1:0] chain;
    logic         en;
    logic         run;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  // Reference model: the ramp is tracked as a step count mapped onto a
  // triangle, not as an up/down register.
  logic [N-1:0] m_chain, m_state;
  int m_level, m_steps, m_phase, m_div;
  logic m_run, m_en1, m_en2;

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int tri_level(input int s);
    int p;
    p = s % (2 * N);
    return (p <= N) ? p : 2 * N - p;
  endfunction

  function automatic logic [N-1:0] therm(input int lvl);
    logic [N-1:0] t;
    for (int k = 0; k < N; k++) t[k] = (k < lvl);
    return t;
  endfunction

  task automatic model_reset();
    m_chain = '0; m_state = '0; m_level = 0; m_steps = 0;
    m_phase = 0; m_div = 0; m_run = 1'b0; m_en1 = 1'b0; m_en2 = 1'b0;
  endtask

  task automatic model_step();
    int old_level;
    int code;
    old_level = m_level;
    m_en2 = m_en1;
    m_en1 = en_in;
    if (mode != 2'd2) begin
      m_run = 1'b0;
      m_phase = 0;
    end else if (m_run) begin
      if (m_phase == m_div) begin
        m_phase = 0;
        m_steps++;
        m_level = tri_level(m_steps);
        m_state = therm(m_level);
      end else begin
        m_phase++;
      end
    end
    if (transfer) begin
      case (mode)
        2'd0: if (dir) m_state = m_chain; else m_chain = m_state;
        2'd1: begin
          if (dir) begin
            code = int'(m_chain[CW-1:0]);
            m_level = (code > N) ? N : code;
            m_state = therm(m_level);
          end else begin
            m_chain = '0;
            m_chain[CW-1:0] = CW'(old_level);
          end
        end
        2'd2: begin
          if (dir) begin
            m_div = int'(m_chain[DIVW-1:0]);
            m_steps = 0; m_level = 0; m_phase = 0; m_run = 1'b1;
            m_state = '0;
          end else begin
            m_chain = '0;
            m_chain[CW-1:0] = CW'(old_level);
          end
        end
        default: ;
      endcase
    end else if (shift) begin
      m_chain = {m_chain[N-LANES-1:0], data_in};
    end
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    model_step();
    e.state = m_state; e.chain = m_chain; e.en = m_en2; e.run = m_run;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      chk("cell_on", cell_on, mon_e.state);
      chk("cell_on_b", cell_on_b, ~mon_e.state);
      chk("state_tap", {{(N-TAPW){1'b0}}, state_tap}, {{(N-TAPW){1'b0}}, mon_e.state[N-1 -: TAPW]});
      chk("chain_tap", {{(N-TAPW){1'b0}}, chain_tap}, {{(N-TAPW){1'b0}}, mon_e.chain[N-1 -: TAPW]});
      chk("dac_en", {{(N-1){1'b0}}, dac_en}, {{(N-1){1'b0}}, mon_e.en});
      chk("busy", {{(N-1){1'b0}}, busy}, {{(N-1){1'b0}}, mon_e.run && (mode == 2'd2)});
    end
  end

  task automatic shift_bits(input logic [N-1:0] v, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) begin
      shift = 1'b1; transfer = 1'b0; data_in = v[i];
      tick();
    end
    shift = 1'b0;
  endtask

  task automatic xfer(input logic [1:0] md, input logic dr);
    mode = md; dir = dr; transfer = 1'b1; shift = 1'b0;
    tick();
    transfer = 1'b0;
  endtask

  task automatic idle(input int n);
    shift = 1'b0; transfer = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_cell_on"}, cell_on, '0);
    chk({tag, "_cell_on_b"}, cell_on_b, '1);
    chk({tag, "_busy"}, {{(N-1){1'b0}}, busy}, '0);
    chk({tag, "_dac_en"}, {{(N-1){1'b0}}, dac_en}, '0);
    chk({tag, "_chain_tap"}, {{(N-TAPW){1'b0}}, chain_tap}, '0);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must drop immediately.
  task automatic do_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_values("async_rst");
    model_reset();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout bench did not finish actual=running required=done");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] pat;
    int codes[6];
    rst_n = 1'b0; data_in = '0; shift = 1'b0; transfer = 1'b0;
    dir = 1'b0; mode = 2'd0; en_in = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #2 check_reset_values("init_rst");
    @(negedge clk);
    #1 rst_n = 1'b1;

    // DIRECT load and readback
    pat = {16{8'hA5}};
    mode = 2'd0;
    shift_bits(pat, N);
    xfer(2'd0, 1'b1);
    idle(2);
    shift_bits('0, N);
    xfer(2'd0, 1'b0);
    idle(2);

    // THERMO loads including clamp and edges, then readback
    codes = '{37, 200, 0, 128, 127, 1};
    foreach (codes[i]) begin
      mode = 2'd1;
      shift_bits(N'(codes[i]), CW);
      xfer(2'd1, 1'b1);
      idle(1);
    end
    mode = 2'd1;
    shift_bits(N'(37), CW);
    xfer(2'd1, 1'b1);
    xfer(2'd1, 1'b0);
    shift_bits('0, N - CW);

    // RAMP div=2 through a full triangle, with en_in toggling
    mode = 2'd0;
    shift_bits(N'(2), DIVW);
    xfer(2'd2, 1'b1);
    for (int i = 0; i < 40; i++) begin
      en_in = ~en_in;
      idle(20);
    end

    // RAMP div=0, freeze via HOLD, re-enter without restart, readback
    mode = 2'd0;
    shift_bits('0, DIVW);
    xfer(2'd2, 1'b1);
    idle(50);
    mode = 2'd3;
    idle(5);
    mode = 2'd2;
    idle(3);
    xfer(2'd2, 1'b0);
    mode = 2'd3;
    shift_bits('0, N - CW);

    // shift and transfer in the same cycle: transfer wins
    mode = 2'd0; shift = 1'b1; data_in = 1'b1; dir = 1'b1; transfer = 1'b1;
    tick();
    shift = 1'b0; transfer = 1'b0;
    idle(2);

    // restart while running, then reset mid-sweep
    mode = 2'd0;
    shift_bits(N'(1), DIVW);
    xfer(2'd2, 1'b1);
    idle(40);
    xfer(2'd2, 1'b1);
    en_in = 1'b1;
    idle(30);
    do_reset();
    en_in = 1'b0;
    idle(4);

    // random traffic
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
      transfer = ($urandom_range(0, 7) == 0);
      dir      = 1'($urandom_range(0, 1));
      shift    = 1'($urandom_range(0, 1));
      data_in  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 9) == 0) en_in = ~en_in;
      tick();
    end
    idle(2);

    @(negedge clk);
    @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_drain actual=%0d required=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
